// File: rtl/alu_seq_if.sv
// Request and register-file bus bundle for alu_seq.
interface alu_seq_if;
  logic       start;
  logic [2:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rd;
  logic       busy;
  logic       done;
  logic       rf_enb;
  logic       rf_rw;
  logic [3:0] rf_sel;
  logic [7:0] rf_wdata;
  logic [7:0] rf_rdata;
  logic [7:0] result;
  logic       flag_c;
  logic       flag_z;

  modport master (
    output start, op, ra, rb, rd, rf_rdata,
    input  busy, done, rf_enb, rf_rw, rf_sel,
    input  rf_wdata, result, flag_c, flag_z
  );

  modport slave (
    input  start, op, ra, rb, rd, rf_rdata,
    output busy, done, rf_enb, rf_rw, rf_sel,
    output rf_wdata, result, flag_c, flag_z
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential 8-bit ALU over an external register file.
// Flag registers are built only when ALU_SEQ_FLAGS_EN is defined.
module alu_seq (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, RDA, RDB, EXE, WB, DN
  } state_t;

  state_t     state, state_n;
  logic [2:0] op_q;
  logic [3:0] ra_q, rb_q, rd_q;
  logic [7:0] a_q, b_q;
  logic [7:0] result_q;
  logic [7:0] res_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.start) begin
        op_q <= bus.op;
        ra_q <= bus.ra;
        rb_q <= bus.rb;
        rd_q <= bus.rd;
      end
      if (state == RDA) a_q <= bus.rf_rdata;
      if (state == RDB) b_q <= bus.rf_rdata;
      if (state == EXE) result_q <= res_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (bus.start) state_n = RDA;
      RDA:  state_n = RDB;
      RDB:  state_n = EXE;
      EXE:  state_n = WB;
      WB:   state_n = DN;
      DN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    res_n = '0;
    unique case (op_q)
      3'b000: res_n = a_q + b_q;
      3'b001: res_n = a_q - b_q;
      3'b010: res_n = a_q & b_q;
      3'b011: res_n = a_q | b_q;
      3'b100: res_n = a_q ^ b_q;
      3'b101: res_n = ~a_q;
      3'b110: res_n = {a_q[6:0], 1'b0};
      3'b111: res_n = b_q;
      default: res_n = '0;
    endcase
  end

  // Bus decode is purely combinational so it settles before the RF's negedge.
  always_comb begin
    bus.busy     = (state != IDLE);
    bus.done     = 1'b0;
    bus.rf_enb   = 1'b0;
    bus.rf_rw    = 1'b1;
    bus.rf_sel   = '0;
    bus.rf_wdata = result_q;
    unique case (state)
      RDA: begin
        bus.rf_enb = 1'b1;
        bus.rf_sel = ra_q;
      end
      RDB: begin
        bus.rf_enb = 1'b1;
        bus.rf_sel = rb_q;
      end
      WB: begin
        bus.rf_enb = 1'b1;
        bus.rf_rw  = 1'b0;
        bus.rf_sel = rd_q;
      end
      DN:      bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.result = result_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic [8:0] sum;
  logic       c_n;
  logic       c_q, z_q;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    c_n = 1'b0;
    unique case (op_q)
      3'b000:  c_n = sum[8];
      3'b001:  c_n = (a_q < b_q);
      3'b110:  c_n = a_q[7];
      default: c_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
    end else if (state == EXE) begin
      c_q <= c_n;
      z_q <= (res_n == 8'h00);
    end
  end

  assign bus.flag_c = c_q;
  assign bus.flag_z = z_q;
`else
  assign bus.flag_c = 1'b0;
  assign bus.flag_z = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a negedge 16x8 register-file model.
module tb_alu_seq;

`ifdef ALU_SEQ_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  alu_seq_if bus ();

  alu_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rf [16];
  logic       pl_en;
  logic [3:0] pl_idx;
  logic [7:0] pl_val;

  always @(negedge clk) begin
    if (pl_en)
      rf[pl_idx] <= pl_val;
    else if (bus.rf_enb && bus.rf_rw)
      bus.rf_rdata <= rf[bus.rf_sel];
    else if (bus.rf_enb)
      rf[bus.rf_sel] <= bus.rf_wdata;
  end

  int n_chk;
  int n_fail;
  logic [3:0] sel_log [8];
  logic       rw_log  [8];
  logic       enb_log [8];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] i, input logic [7:0] v);
    pl_idx = i;
    pl_val = v;
    pl_en  = 1'b1;
    @(negedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o,
                        input logic [3:0] a, b, d,
                        input logic [7:0] er,
                        input logic ec, ez);
    int cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.ra    = a;
    bus.rb    = b;
    bus.rd    = d;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cnt = 0;
    while (!bus.done && cnt < 10) begin
      if (cnt < 8) begin
        sel_log[cnt] = bus.rf_sel;
        rw_log[cnt]  = bus.rf_rw;
        enb_log[cnt] = bus.rf_enb;
      end
      @(posedge clk);
      #1;
      cnt++;
    end
    check("latency", cnt, 4);
    check("result", bus.result, er);
    check("flag_c", bus.flag_c, ec & FLAGS_EN);
    check("flag_z", bus.flag_z, ez & FLAGS_EN);
    check("rf_wb", rf[d], er);
    @(posedge clk);
    #1;
    check("done_pulse", bus.done, 1'b0);
    check("busy_end", bus.busy, 1'b0);
  endtask

  initial begin
    int dn, wr, t0, t1;
    n_chk  = 0;
    n_fail = 0;
    pl_en  = 1'b0;
    pl_idx = '0;
    pl_val = '0;
    bus.start = 1'b0;
    bus.op = '0;
    bus.ra = '0;
    bus.rb = '0;
    bus.rd = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_enb", bus.rf_enb, 1'b0);
    check("rst_result", bus.result, 8'h00);
    check("rst_flags", {bus.flag_c, bus.flag_z}, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    preload(4'd1, 8'hF0);
    preload(4'd2, 8'h20);
    run_op(3'b000, 4'd1, 4'd2, 4'd3, 8'h10, 1'b1, 1'b0);

    preload(4'd4, 8'h05);
    preload(4'd5, 8'h07);
    run_op(3'b001, 4'd4, 4'd5, 4'd6, 8'hFE, 1'b1, 1'b0);
    preload(4'd5, 8'h05);
    run_op(3'b001, 4'd4, 4'd5, 4'd6, 8'h00, 1'b0, 1'b1);

    preload(4'd7, 8'h81);
    run_op(3'b110, 4'd7, 4'd0, 4'd7, 8'h02, 1'b1, 1'b0);
    check("seq_sel_rda", sel_log[0], 4'd7);
    check("seq_rw_rda", rw_log[0], 1'b1);
    check("seq_rw_rdb", rw_log[1], 1'b1);
    check("seq_enb_exe", enb_log[2], 1'b0);
    check("seq_sel_wb", sel_log[3], 4'd7);
    check("seq_rw_wb", rw_log[3], 1'b0);
    check("seq_enb_wb", enb_log[3], 1'b1);

    preload(4'd10, 8'hCA);
    preload(4'd11, 8'h0F);
    run_op(3'b010, 4'd10, 4'd11, 4'd12, 8'h0A, 1'b0, 1'b0);
    run_op(3'b011, 4'd10, 4'd11, 4'd12, 8'hCF, 1'b0, 1'b0);
    run_op(3'b100, 4'd10, 4'd11, 4'd12, 8'hC5, 1'b0, 1'b0);
    run_op(3'b101, 4'd10, 4'd11, 4'd12, 8'h35, 1'b0, 1'b0);

    dn = 0;
    wr = 0;
    t0 = -1;
    t1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = (i < 12);
      bus.op = 3'b000;
      bus.ra = 4'd1;
      bus.rb = 4'd2;
      bus.rd = 4'd8;
      @(posedge clk);
      #1;
      if (bus.done) begin
        if (dn == 0) t0 = i;
        else t1 = i;
        dn++;
      end
      if (bus.rf_enb && !bus.rf_rw) wr++;
    end
    check("burst_done_cnt", dn, 2);
    check("burst_first", t0, 4);
    check("burst_gap", t1 - t0, 6);
    check("burst_writes", wr, 2);
    check("burst_r8", rf[8], 8'h10);

    preload(4'd9, 8'h3C);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'b111;
    bus.ra = 4'd0;
    bus.rb = 4'd9;
    bus.rd = 4'd13;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_wb", bus.rf_enb, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_enb", bus.rf_enb, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_result", bus.result, 8'h00);
    @(negedge clk);
    #1;
    rst = 1'b0;
    run_op(3'b111, 4'd0, 4'd9, 4'd14, 8'h3C, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
